// File: rtl/pipelined_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_mac_acc
// Description : Unsigned WIDTH x WIDTH pipelined array multiplier feeding a
//               registered accumulator with clear, bypass and saturate/wrap.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pipelined_mac_acc #(
    parameter int WIDTH     = 4,
    parameter int PIPE      = 3,
    parameter int ACC_WIDTH = 12,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     y,
    input  logic                 acc_clr,
    input  logic                 acc_en,
    output logic [ACC_WIDTH-1:0] out,
    output logic                 out_valid,
    output logic                 overflow
);

    localparam int c_PROD_W = 2 * WIDTH;
    localparam int c_ROWS   = (WIDTH + PIPE - 1) / PIPE;

    // Index 0 is the input capture register; indices 1..PIPE each fold in one
    // group of partial-product rows.
    logic [WIDTH-1:0]     r_a    [0:PIPE-1];
    logic [WIDTH-1:0]     r_y    [0:PIPE-1];
    logic [c_PROD_W-1:0]  r_psum [1:PIPE];
    logic [c_PROD_W-1:0]  w_psum_next [1:PIPE];
    logic [PIPE:0]        r_vld;
    logic [PIPE:0]        r_clr;
    logic [PIPE:0]        r_en;

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_out;
    logic                 r_out_vld;
    logic                 r_ovf;
    logic [ACC_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic [ACC_WIDTH-1:0] w_out_next;
    logic                 w_ovf_next;

    function automatic logic [c_PROD_W-1:0] rows_sum(
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fy,
        input int               lo,
        input int               hi
    );
        logic [c_PROD_W-1:0] s;
        s = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (j >= lo && j < hi && fy[j]) begin
                s = s + (c_PROD_W'(fa) << j);
            end
        end
        return s;
    endfunction

    for (genvar k = 1; k <= PIPE; k++) begin : g_stage
        localparam int c_LO = (k - 1) * c_ROWS;
        localparam int c_HI = k * c_ROWS;
        if (k == 1) begin : g_first
            assign w_psum_next[k] = rows_sum(r_a[k-1], r_y[k-1], c_LO, c_HI);
        end else begin : g_rest
            assign w_psum_next[k] = r_psum[k-1] + rows_sum(r_a[k-1], r_y[k-1], c_LO, c_HI);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_clr <= '0;
            r_en  <= '0;
            for (int k = 0; k < PIPE; k++) begin
                r_a[k] <= '0;
                r_y[k] <= '0;
            end
            for (int k = 1; k <= PIPE; k++) begin
                r_psum[k] <= '0;
            end
        end else begin
            r_vld  <= {r_vld[PIPE-1:0], in_valid};
            r_clr  <= {r_clr[PIPE-1:0], acc_clr};
            r_en   <= {r_en[PIPE-1:0], acc_en};
            r_a[0] <= a;
            r_y[0] <= y;
            for (int k = 1; k < PIPE; k++) begin
                r_a[k] <= r_a[k-1];
                r_y[k] <= r_y[k-1];
            end
            for (int k = 1; k <= PIPE; k++) begin
                r_psum[k] <= w_psum_next[k];
            end
        end
    end

    assign w_prod = ACC_WIDTH'(r_psum[PIPE]);
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_prod};

    // Accumulate stage works only on its own registers, so consecutive
    // samples never see a stale accumulator value.
    always_comb begin
        w_acc_next = r_acc;
        w_out_next = r_out;
        w_ovf_next = r_ovf;
        if (r_vld[PIPE]) begin
            if (!r_en[PIPE]) begin
                w_out_next = w_prod;
            end else if (r_clr[PIPE]) begin
                w_acc_next = w_prod;
                w_out_next = w_prod;
                w_ovf_next = 1'b0;
            end else if (w_sum[ACC_WIDTH]) begin
                w_ovf_next = 1'b1;
                w_acc_next = SATURATE ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
                w_out_next = w_acc_next;
            end else begin
                w_acc_next = w_sum[ACC_WIDTH-1:0];
                w_out_next = w_sum[ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_out     <= '0;
            r_out_vld <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_acc     <= w_acc_next;
            r_out     <= w_out_next;
            r_out_vld <= r_vld[PIPE];
            r_ovf     <= w_ovf_next;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_vld;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_mac_acc
// Description : Scoreboard bench for pipelined_mac_acc (saturating, wrapping
//               and wide-parameter instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_mac_acc;

    localparam int PIPE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  a = '0;
    logic [3:0]  y = '0;
    logic        acc_clr = 1'b0;
    logic        acc_en = 1'b0;
    logic [11:0] out_s, out_w;
    logic        ov_s, ov_w, ovf_s, ovf_w;

    logic        wv = 1'b0;
    logic [7:0]  wa = '0;
    logic [7:0]  wy = '0;
    logic        wclr = 1'b0;
    logic        wen = 1'b0;
    logic [19:0] out_x;
    logic        ov_x, ovf_x;

    always #5 clk = ~clk;

    pipelined_mac_acc #(.WIDTH(4), .PIPE(PIPE), .ACC_WIDTH(12), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .y(y),
        .acc_clr(acc_clr), .acc_en(acc_en),
        .out(out_s), .out_valid(ov_s), .overflow(ovf_s)
    );

    pipelined_mac_acc #(.WIDTH(4), .PIPE(PIPE), .ACC_WIDTH(12), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .y(y),
        .acc_clr(acc_clr), .acc_en(acc_en),
        .out(out_w), .out_valid(ov_w), .overflow(ovf_w)
    );

    pipelined_mac_acc #(.WIDTH(8), .PIPE(4), .ACC_WIDTH(20), .SATURATE(1'b1)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(wv), .a(wa), .y(wy),
        .acc_clr(wclr), .acc_en(wen),
        .out(out_x), .out_valid(ov_x), .overflow(ovf_x)
    );

    typedef struct {
        int          cyc;
        logic [11:0] val;
        logic        ovf;
    } exp_t;

    exp_t q_s[$];
    exp_t q_w[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic rst_q = 1'b1;

    logic [11:0] m_acc_s = '0, m_acc_w = '0;
    logic        m_ovf_s = 1'b0, m_ovf_w = 1'b0;
    logic [11:0] last_s = '0, last_w = '0;
    logic        lov_s = 1'b0, lov_w = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Scoreboard consumer: exact-cycle result checks plus hold checks on idle cycles.
    always @(negedge clk) begin
        exp_t e;
        if (ov_s) begin
            checks++;
            if (q_s.size() == 0) begin
                errors++;
                $display("FAIL sat_unexpected: out_valid=1 out=%0d at cycle %0d, required no output", out_s, cyc);
            end else begin
                e = q_s.pop_front();
                if (cyc != e.cyc || out_s !== e.val || ovf_s !== e.ovf) begin
                    errors++;
                    $display("FAIL sat_result: cycle=%0d out=%0d overflow=%b, required cycle=%0d out=%0d overflow=%b",
                             cyc, out_s, ovf_s, e.cyc, e.val, e.ovf);
                end
            end
        end else begin
            if (q_s.size() != 0 && q_s[0].cyc <= cyc) begin
                checks++;
                errors++;
                e = q_s.pop_front();
                $display("FAIL sat_missing: out_valid=0 at cycle %0d, required out=%0d at cycle %0d", cyc, e.val, e.cyc);
            end
            if (!rst_q) begin
                checks++;
                if (out_s !== last_s || ovf_s !== lov_s) begin
                    errors++;
                    $display("FAIL sat_hold: out=%0d overflow=%b, required held out=%0d overflow=%b", out_s, ovf_s, last_s, lov_s);
                end
            end
        end
        if (ov_w) begin
            checks++;
            if (q_w.size() == 0) begin
                errors++;
                $display("FAIL wrap_unexpected: out_valid=1 out=%0d at cycle %0d, required no output", out_w, cyc);
            end else begin
                e = q_w.pop_front();
                if (cyc != e.cyc || out_w !== e.val || ovf_w !== e.ovf) begin
                    errors++;
                    $display("FAIL wrap_result: cycle=%0d out=%0d overflow=%b, required cycle=%0d out=%0d overflow=%b",
                             cyc, out_w, ovf_w, e.cyc, e.val, e.ovf);
                end
            end
        end else begin
            if (q_w.size() != 0 && q_w[0].cyc <= cyc) begin
                checks++;
                errors++;
                e = q_w.pop_front();
                $display("FAIL wrap_missing: out_valid=0 at cycle %0d, required out=%0d at cycle %0d", cyc, e.val, e.cyc);
            end
            if (!rst_q) begin
                checks++;
                if (out_w !== last_w || ovf_w !== lov_w) begin
                    errors++;
                    $display("FAIL wrap_hold: out=%0d overflow=%b, required held out=%0d overflow=%b", out_w, ovf_w, last_w, lov_w);
                end
            end
        end
        last_s = out_s;
        lov_s  = ovf_s;
        last_w = out_w;
        lov_w  = ovf_w;
    end

    // Drives one cycle on the narrow instances and records the expected result.
    task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] ty,
                         input logic clr, input logic en);
        logic [11:0] p;
        logic [12:0] s;
        logic [11:0] vs, vw;
        exp_t        e;
        @(negedge clk);
        in_valid = v;
        a        = ta;
        y        = ty;
        acc_clr  = clr;
        acc_en   = en;
        if (v) begin
            p = 12'(ta) * 12'(ty);
            if (!en) begin
                vs = p;
                vw = p;
            end else if (clr) begin
                m_acc_s = p; m_ovf_s = 1'b0;
                m_acc_w = p; m_ovf_w = 1'b0;
                vs = p;
                vw = p;
            end else begin
                s = {1'b0, m_acc_s} + {1'b0, p};
                if (s[12]) begin
                    m_ovf_s = 1'b1;
                    m_acc_s = 12'hFFF;
                end else begin
                    m_acc_s = s[11:0];
                end
                s = {1'b0, m_acc_w} + {1'b0, p};
                if (s[12]) m_ovf_w = 1'b1;
                m_acc_w = s[11:0];
                vs = m_acc_s;
                vw = m_acc_w;
            end
            e.cyc = cyc + PIPE + 2;
            e.val = vs;
            e.ovf = m_ovf_s;
            q_s.push_back(e);
            e.val = vw;
            e.ovf = m_ovf_w;
            q_w.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic flush_model();
        q_s.delete();
        q_w.delete();
        m_acc_s = '0; m_ovf_s = 1'b0;
        m_acc_w = '0; m_ovf_w = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        a = 4'd15;
        y = 4'd15;
        flush_model();
        repeat (3) @(negedge clk);
        checks++;
        if (out_s !== 12'd0 || ov_s !== 1'b0 || ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat: out=%0d out_valid=%b overflow=%b, required 0 0 0", out_s, ov_s, ovf_s);
        end
        checks++;
        if (out_w !== 12'd0 || ov_w !== 1'b0 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap: out=%0d out_valid=%b overflow=%b, required 0 0 0", out_w, ov_w, ovf_w);
        end
        checks++;
        if (out_x !== 20'd0 || ov_x !== 1'b0 || ovf_x !== 1'b0) begin
            errors++;
            $display("FAIL reset_wide: out=%0d out_valid=%b overflow=%b, required 0 0 0", out_x, ov_x, ovf_x);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        idle(PIPE + 3);
    endtask

    task automatic test_mult_only();
        drive(1'b1, 4'd9, 4'd6, 1'b0, 1'b0);
        idle(PIPE + 3);
        checks++;
        if (out_s !== 12'd54 || ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL mult_only: out=%0d overflow=%b, required out=54 overflow=0", out_s, ovf_s);
        end
    endtask

    task automatic test_accumulate();
        drive(1'b1, 4'd3, 4'd2, 1'b1, 1'b1);
        drive(1'b1, 4'd10, 4'd5, 1'b0, 1'b1);
        drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b1);
        idle(PIPE + 3);
        checks++;
        if (out_s !== 12'd281 || out_w !== 12'd281) begin
            errors++;
            $display("FAIL accumulate: out_sat=%0d out_wrap=%0d, required 281", out_s, out_w);
        end
    endtask

    task automatic test_bubbles();
        drive(1'b1, 4'd3, 4'd2, 1'b1, 1'b1);
        idle(2);
        drive(1'b1, 4'd10, 4'd5, 1'b0, 1'b1);
        idle(1);
        drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b1);
        idle(PIPE + 3);
        checks++;
        if (out_s !== 12'd281) begin
            errors++;
            $display("FAIL bubbles: out=%0d, required 281", out_s);
        end
    endtask

    task automatic test_saturate_wrap();
        drive(1'b1, 4'd15, 4'd15, 1'b1, 1'b1);
        for (int i = 0; i < 18; i++) drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b1);
        idle(PIPE + 3);
        checks++;
        if (out_s !== 12'd4095 || ovf_s !== 1'b1) begin
            errors++;
            $display("FAIL saturate_19: out=%0d overflow=%b, required 4095 1", out_s, ovf_s);
        end
        checks++;
        if (out_w !== 12'd179 || ovf_w !== 1'b1) begin
            errors++;
            $display("FAIL wrap_19: out=%0d overflow=%b, required 179 1", out_w, ovf_w);
        end
        drive(1'b1, 4'd1, 4'd1, 1'b0, 1'b1);
        idle(PIPE + 3);
        checks++;
        if (out_s !== 12'd4095 || ovf_s !== 1'b1 || out_w !== 12'd180) begin
            errors++;
            $display("FAIL saturate_hold: out_sat=%0d overflow=%b out_wrap=%0d, required 4095 1 180", out_s, ovf_s, out_w);
        end
        drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1);
        idle(PIPE + 3);
        checks++;
        if (out_s !== 12'd6 || ovf_s !== 1'b0 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_sat: out=%0d overflow_sat=%b overflow_wrap=%b, required 6 0 0", out_s, ovf_s, ovf_w);
        end
    endtask

    task automatic test_reset_flight();
        drive(1'b1, 4'd15, 4'd15, 1'b1, 1'b1);
        for (int i = 0; i < 18; i++) drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b1);
        idle(PIPE + 3);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd5, 4'd5, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        flush_model();
        @(negedge clk);
        rst = 1'b0;
        idle(PIPE + 3);
        checks++;
        if (out_s !== 12'd0 || ovf_s !== 1'b0 || out_w !== 12'd0 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_flight: out_sat=%0d ovf_sat=%b out_wrap=%0d ovf_wrap=%b, required all 0",
                     out_s, ovf_s, out_w, ovf_w);
        end
        drive(1'b1, 4'd7, 4'd9, 1'b0, 1'b0);
        idle(PIPE + 3);
        checks++;
        if (out_s !== 12'd63) begin
            errors++;
            $display("FAIL after_reset: out=%0d, required 63", out_s);
        end
    endtask

    task automatic test_param_sweep();
        @(negedge clk);
        wv = 1'b1;
        wa = 8'd255;
        wy = 8'd255;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            wv = 1'b0;
            checks++;
            if (ov_x !== (k == 5)) begin
                errors++;
                $display("FAIL wide_valid: edge+%0d out_valid=%b, required %b", k, ov_x, (k == 5));
            end
            if (k == 5) begin
                checks++;
                if (out_x !== 20'd65025 || ovf_x !== 1'b0) begin
                    errors++;
                    $display("FAIL wide_result: out=%0d overflow=%b, required 65025 0", out_x, ovf_x);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_only();
        test_accumulate();
        test_bubbles();
        test_saturate_wrap();
        test_reset_flight();
        test_param_sweep();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
